// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                          |
// | Description : Request/response and memory-side bus of mem_arbiter.    |
// |               slave = arbiter view, master = environment view.        |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  // IFU channel
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_rdata;
  // LSU channel
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [7:0]  lsu_wmask;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_rdata;
  // memory side
  logic        mem_valid;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_wmask, lsu_addr, lsu_wdata, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_valid, mem_wen, mem_wmask, mem_raddr, mem_waddr, mem_wdata
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_wmask, lsu_addr, lsu_wdata, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_valid, mem_wen, mem_wmask, mem_raddr, mem_waddr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                             |
// | Description : Round-robin arbiter sharing one data memory between the |
// |               IFU (read-only) and the LSU (read/write). One access at |
// |               a time, held LATENCY cycles, single-cycle mem strobe.   |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 4
) (
  input wire           clk,
  input wire           rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_BUSY   = 2'd1;
  localparam logic [1:0]       S_RESP   = 2'd2;
  localparam logic             OWN_IFU  = 1'b0;
  localparam logic             OWN_LSU  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [31:0]      addr_q, addr_d;
  logic             wen_q, wen_d;
  logic [7:0]       wmask_q, wmask_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic grant_ifu;
  logic grant_lsu;
  logic strobe;
  logic owner_resp_ready;
  logic in_resp;

  // Grant in IDLE: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n && (state_q == S_IDLE)) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        if (last_q == OWN_IFU) grant_lsu = 1'b1;
        else                   grant_ifu = 1'b1;
      end else begin
        grant_ifu = bus.ifu_req_valid;
        grant_lsu = bus.lsu_req_valid;
      end
    end
  end

  assign owner_resp_ready = (owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  // Transaction sequencing: latch request, count down latency, strobe memory, hold response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    strobe  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_lsu) begin
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wmask_d = bus.lsu_wmask;
          wdata_d = bus.lsu_wdata;
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end else if (grant_ifu) begin
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wmask_d = 8'h00;
          wdata_d = 32'h0;
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // memory data is combinational, so the pre-write word is captured here
          strobe  = 1'b1;
          rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
      addr_q  <= 32'h0;
      wen_q   <= 1'b0;
      wmask_q <= 8'h00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_resp = (state_q == S_RESP);

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.ifu_resp_valid = in_resp && (owner_q == OWN_IFU);
  assign bus.lsu_resp_valid = in_resp && (owner_q == OWN_LSU);
  assign bus.ifu_rdata      = bus.ifu_resp_valid ? rdata_q : 32'h0;
  assign bus.lsu_rdata      = bus.lsu_resp_valid ? rdata_q : 32'h0;

  // write-side fields are only meaningful during the strobe
  assign bus.mem_valid = strobe;
  assign bus.mem_wen   = strobe && wen_q;
  assign bus.mem_wmask = strobe ? wmask_q : 8'h00;
  assign bus.mem_wdata = strobe ? wdata_q : 32'h0;
  assign bus.mem_raddr = addr_q;
  assign bus.mem_waddr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                          |
// | Description : Scoreboard bench for mem_arbiter at LATENCY 1 and 4.    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  typedef struct {
    logic        owner;   // 0 = IFU, 1 = LSU
    logic        wen;
    logic [7:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          hs;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;              // 0 -> LATENCY=1 instance, 1 -> LATENCY=4 instance
  int   lat;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cyc = -1;
  int   strobes = 0;

  logic        ifu_v, ifu_rr, lsu_v, lsu_wen, lsu_rr;
  logic [31:0] ifu_a, lsu_a, lsu_wd;
  logic [7:0]  lsu_wm;

  logic        ifu_rdy, ifu_rv, lsu_rdy, lsu_rv, m_valid, m_wen;
  logic [31:0] ifu_rd, lsu_rd, m_raddr, m_waddr, m_wdata;
  logic [7:0]  m_wmask;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic        ref_last [2];
  entry_t      q[$];
  entry_t      e_mon;
  entry_t      e_pred;
  logic [1:0]  exp_rdy;
  logic        idle;

  mem_arbiter_if bus1();
  mem_arbiter_if bus4();

  mem_arbiter #(.LATENCY(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mem_arbiter #(.LATENCY(4), .CNT_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign lat = sel ? 4 : 1;

  assign bus1.ifu_req_valid  = ifu_v & ~sel;
  assign bus4.ifu_req_valid  = ifu_v & sel;
  assign bus1.lsu_req_valid  = lsu_v & ~sel;
  assign bus4.lsu_req_valid  = lsu_v & sel;
  assign bus1.ifu_addr = ifu_a;       assign bus4.ifu_addr = ifu_a;
  assign bus1.ifu_resp_ready = ifu_rr; assign bus4.ifu_resp_ready = ifu_rr;
  assign bus1.lsu_wen = lsu_wen;      assign bus4.lsu_wen = lsu_wen;
  assign bus1.lsu_wmask = lsu_wm;     assign bus4.lsu_wmask = lsu_wm;
  assign bus1.lsu_addr = lsu_a;       assign bus4.lsu_addr = lsu_a;
  assign bus1.lsu_wdata = lsu_wd;     assign bus4.lsu_wdata = lsu_wd;
  assign bus1.lsu_resp_ready = lsu_rr; assign bus4.lsu_resp_ready = lsu_rr;
  assign bus1.mem_rdata = mem[bus1.mem_raddr[11:2]];
  assign bus4.mem_rdata = mem[bus4.mem_raddr[11:2]];

  assign ifu_rdy = sel ? bus4.ifu_req_ready  : bus1.ifu_req_ready;
  assign ifu_rv  = sel ? bus4.ifu_resp_valid : bus1.ifu_resp_valid;
  assign ifu_rd  = sel ? bus4.ifu_rdata      : bus1.ifu_rdata;
  assign lsu_rdy = sel ? bus4.lsu_req_ready  : bus1.lsu_req_ready;
  assign lsu_rv  = sel ? bus4.lsu_resp_valid : bus1.lsu_resp_valid;
  assign lsu_rd  = sel ? bus4.lsu_rdata      : bus1.lsu_rdata;
  assign m_valid = sel ? bus4.mem_valid : bus1.mem_valid;
  assign m_wen   = sel ? bus4.mem_wen   : bus1.mem_wen;
  assign m_wmask = sel ? bus4.mem_wmask : bus1.mem_wmask;
  assign m_raddr = sel ? bus4.mem_raddr : bus1.mem_raddr;
  assign m_waddr = sel ? bus4.mem_waddr : bus1.mem_waddr;
  assign m_wdata = sel ? bus4.mem_wdata : bus1.mem_wdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [7:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    return {20'h80000, w, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory behind the arbiter: byte-masked write on the strobe
  always @(posedge clk) begin
    if (m_valid && m_wen) mem[m_waddr[11:2]] <= merge(mem[m_waddr[11:2]], m_wdata, m_wmask);
  end

  // Predictor: transaction-level arbitration and memory model; pushes expected responses
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", {ifu_rdy, lsu_rdy}, 2'b00);
    end else begin
      idle    = (q.size() == 0) && (cyc > done_cyc);
      exp_rdy = 2'b00;
      if (idle) begin
        if (ifu_v && lsu_v) exp_rdy = ref_last[sel] ? 2'b10 : 2'b01;
        else if (ifu_v)     exp_rdy = 2'b10;
        else if (lsu_v)     exp_rdy = 2'b01;
      end
      chk("req_ready", {ifu_rdy, lsu_rdy}, exp_rdy);
      if (exp_rdy != 2'b00) begin
        e_pred.owner = (exp_rdy == 2'b01);
        e_pred.hs    = cyc;
        if (e_pred.owner) begin
          e_pred.addr = lsu_a; e_pred.wen = lsu_wen; e_pred.wmask = lsu_wm; e_pred.wdata = lsu_wd;
        end else begin
          e_pred.addr = ifu_a; e_pred.wen = 1'b0; e_pred.wmask = 8'h00; e_pred.wdata = 32'h0;
        end
        e_pred.rdata = ref_mem[e_pred.addr[11:2]];
        if (e_pred.wen)
          ref_mem[e_pred.addr[11:2]] = merge(e_pred.rdata, e_pred.wdata, e_pred.wmask);
        ref_last[sel] = e_pred.owner;
        q.push_back(e_pred);
      end
    end
  end

  // Monitor: checks the memory strobe and responses against the queue head
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {m_valid, ifu_rv, lsu_rv, ifu_rd, lsu_rd, m_raddr}, 0);
    end else begin
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("strobe_unexpected", m_valid, 1'b0);
        end else begin
          e_mon = q[0];
          chk("strobe_time", cyc, e_mon.hs + lat);
          chk("strobe_count", strobes, 0);
          chk("strobe_fields", {m_wen, m_wmask, m_wdata, m_raddr, m_waddr},
              {e_mon.wen, e_mon.wmask, e_mon.wdata, e_mon.addr, e_mon.addr});
          strobes++;
        end
      end else begin
        chk("idle_mem_zero", {m_wen, m_wmask, m_wdata}, 0);
      end
      if (q.size() != 0 && cyc >= q[0].hs + lat + 1) begin
        e_mon = q[0];
        if (cyc == e_mon.hs + lat + 1) chk("strobe_seen", strobes, 1);
        chk("resp_valid", {ifu_rv, lsu_rv}, e_mon.owner ? 2'b01 : 2'b10);
        chk("resp_rdata", e_mon.owner ? lsu_rd : ifu_rd, e_mon.rdata);
        chk("other_rdata", e_mon.owner ? ifu_rd : lsu_rd, 32'h0);
        if (e_mon.owner ? lsu_rr : ifu_rr) begin
          void'(q.pop_front());
          done_cyc = cyc;
          strobes  = 0;
        end
      end else begin
        chk("no_resp", {ifu_rv, lsu_rv, ifu_rd, lsu_rd}, 0);
      end
    end
  end

  task automatic wait_hs(input logic lsu);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (lsu ? lsu_rdy : ifu_rdy) break;
    end
    if (k == 50) chk("handshake_timeout", 1'b1, 1'b0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (k == 200) chk("drain_timeout", 1'b1, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  task automatic req_ifu(input logic [31:0] a);
    @(posedge clk); #1 ifu_v = 1'b1; ifu_a = a;
    wait_hs(1'b0);
    @(posedge clk); #1 ifu_v = 1'b0;
    drain();
  endtask

  task automatic req_lsu(input logic w, input logic [7:0] m, input logic [31:0] a,
                         input logic [31:0] d);
    @(posedge clk); #1 lsu_v = 1'b1; lsu_wen = w; lsu_wm = m; lsu_a = a; lsu_wd = d;
    wait_hs(1'b1);
    @(posedge clk); #1 lsu_v = 1'b0;
    drain();
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ifu_v   = ($urandom_range(0, 2) != 0);
      lsu_v   = ($urandom_range(0, 2) != 0);
      ifu_a   = rand_addr();
      lsu_a   = rand_addr();
      lsu_wen = ($urandom_range(0, 1) != 0);
      lsu_wm  = 8'($urandom_range(0, 255));
      lsu_wd  = $urandom;
      ifu_rr  = ($urandom_range(0, 3) != 0);
      lsu_rr  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 ifu_v = 1'b0; lsu_v = 1'b0; ifu_rr = 1'b1; lsu_rr = 1'b1;
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    ifu_v = 1'b1; lsu_v = 1'b1; ifu_rr = 1'b1; lsu_rr = 1'b1;
    ifu_a = 32'h8000_0000; lsu_a = 32'h8000_0000; lsu_wen = 1'b0; lsu_wm = 8'h00; lsu_wd = 32'h0;
    ref_last[0] = 1'b0; ref_last[1] = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    end
    mem[0] = 32'h0000_0413; ref_mem[0] = 32'h0000_0413;

    // reset state, requests held high to show req_ready is suppressed
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {ifu_rdy, lsu_rdy}, 2'b00);
    chk("reset_outputs", {ifu_rv, lsu_rv, m_valid, m_wen, ifu_rd, lsu_rd}, 0);
    ifu_v = 1'b0; lsu_v = 1'b0;
    #2 rst_n = 1'b1;

    // LATENCY=1 directed traffic
    req_ifu(32'h8000_0000);
    req_lsu(1'b1, 8'h0F, 32'h8000_0100, 32'hDEAD_BEEF);
    req_lsu(1'b0, 8'h00, 32'h8000_0100, 32'h0);
    chk("store_landed", mem[64], 32'hDEAD_BEEF);

    // both requesters always valid: grants alternate
    @(posedge clk); #1 ifu_v = 1'b1; lsu_v = 1'b1; ifu_a = 32'h8000_0010; lsu_a = 32'h8000_0020;
    repeat (24) @(posedge clk);
    #1 ifu_v = 1'b0; lsu_v = 1'b0;
    drain();

    // response back-pressure with competing requests pending
    @(posedge clk); #1 ifu_rr = 1'b0; lsu_rr = 1'b0; ifu_v = 1'b1; lsu_v = 1'b1;
    repeat (8) @(posedge clk);
    #1 ifu_rr = 1'b1; lsu_rr = 1'b1;
    repeat (4) @(posedge clk);
    #1 ifu_v = 1'b0; lsu_v = 1'b0;
    drain();

    rand_phase(300);

    // LATENCY=4 instance
    @(posedge clk); #1 sel = 1'b1;
    req_ifu(32'h8000_0000);
    req_lsu(1'b1, 8'h03, 32'h8000_0200, 32'hCAFE_F00D);
    req_lsu(1'b0, 8'h00, 32'h8000_0200, 32'h0);
    rand_phase(200);

    // reset while BUSY, before the strobe
    @(posedge clk); #1 ifu_v = 1'b1; ifu_a = 32'h8000_0040;
    wait_hs(1'b0);
    @(posedge clk); #1 ifu_v = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {m_valid, ifu_rv, lsu_rv, ifu_rdy, lsu_rdy}, 0);
    q.delete();
    strobes = 0;
    done_cyc = cyc;
    ref_last[0] = 1'b0; ref_last[1] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;

    // service resumes normally; a tie after reset goes to the LSU
    req_ifu(32'h8000_0044);
    @(posedge clk); #1 ifu_v = 1'b1; lsu_v = 1'b1; lsu_wen = 1'b0; lsu_a = 32'h8000_0048;
    repeat (20) @(posedge clk);
    #1 ifu_v = 1'b0; lsu_v = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
